// File: rtl/wb_slave_regfile_if.sv
// Wishbone classic bus bundle between a master and the register-file responder.
`timescale 1ns/1ps
interface wb_slave_regfile_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] adr_i;
    logic [DATA_W-1:0] dat_i;
    logic              we_i;
    logic              cyc_i;
    logic              stb_i;
    logic [DATA_W-1:0] dat_o;
    logic              ack_o;
    logic              err_o;

    modport master (
        output adr_i, dat_i, we_i, cyc_i, stb_i,
        input  dat_o, ack_o, err_o
    );

    modport slave (
        input  adr_i, dat_i, we_i, cyc_i, stb_i,
        output dat_o, ack_o, err_o
    );
endinterface

// File: rtl/wb_slave_regfile.sv
// Wishbone classic responder: 2^ADDR_W x DATA_W register file with optional
// wait states, abort on strobe drop, and a read-only ID word at the top address.
`timescale 1ns/1ps
module wb_slave_regfile #(
    parameter int                 ADDR_W      = 4,
    parameter int                 DATA_W      = 8,
    parameter int                 WAIT_STATES = 0,
    parameter logic [DATA_W-1:0]  ID_VALUE    = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    wb_slave_regfile_if.slave  bus
);
    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ID_ADDR = {ADDR_W{1'b1}};
    localparam logic [3:0]      WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic [3:0]         cnt_r;
    logic [ADDR_W-1:0]  adr_r;
    logic [DATA_W-1:0]  wdat_r;
    logic               we_r;
    logic [DATA_W-1:0]  dat_r;
    logic               ack_r;
    logic               err_r;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               req_s;
    logic               do_access_s;
    logic [ADDR_W-1:0]  acc_adr_s;
    logic [DATA_W-1:0]  acc_dat_s;
    logic               acc_we_s;

    assign req_s     = bus.cyc_i & bus.stb_i;
    assign bus.dat_o = dat_r;
    assign bus.ack_o = ack_r;
    assign bus.err_o = err_r;

    // Decide whether the access happens on this edge, and with which operands
    // (live bus values for zero-wait IDLE, captured values otherwise).
    always_comb begin
        do_access_s = 1'b0;
        acc_adr_s   = adr_r;
        acc_dat_s   = wdat_r;
        acc_we_s    = we_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s && (WAIT_STATES == 0)) begin
                    do_access_s = 1'b1;
                    acc_adr_s   = bus.adr_i;
                    acc_dat_s   = bus.dat_i;
                    acc_we_s    = bus.we_i;
                end else begin
                    do_access_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (req_s && (cnt_r == 4'd0)) begin
                    do_access_s = 1'b1;
                end else begin
                    do_access_s = 1'b0;
                end
            end
            default: begin
                do_access_s = 1'b0;
            end
        endcase
    end

    // Bus FSM: request capture, wait countdown/abort, single-cycle response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            adr_r   <= {ADDR_W{1'b0}};
            wdat_r  <= {DATA_W{1'b0}};
            we_r    <= 1'b0;
            dat_r   <= {DATA_W{1'b0}};
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r <= 1'b0;
                    err_r <= 1'b0;
                    if (req_s) begin
                        adr_r  <= bus.adr_i;
                        wdat_r <= bus.dat_i;
                        we_r   <= bus.we_i;
                        if (!do_access_s) begin
                            cnt_r   <= WAIT_LOAD;
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req_s) begin
                        // Master dropped the cycle: abandon without side effects.
                        state_r <= ST_IDLE;
                    end else if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Requests are deliberately not sampled here so a master
                    // still holding stb after ack cannot cause a repeat access.
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase

            if (do_access_s) begin
                state_r <= ST_RESP;
                if (acc_we_s) begin
                    if (acc_adr_s == ID_ADDR) begin
                        err_r <= 1'b1;
                        ack_r <= 1'b0;
                    end else begin
                        ack_r <= 1'b1;
                        err_r <= 1'b0;
                    end
                end else begin
                    dat_r <= (acc_adr_s == ID_ADDR) ? ID_VALUE : mem[acc_adr_s];
                    ack_r <= 1'b1;
                    err_r <= 1'b0;
                end
            end
        end
    end

    // Register-file storage; the ID address is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {DATA_W{1'b0}};
            end
        end else if (do_access_s && acc_we_s && (acc_adr_s != ID_ADDR)) begin
            mem[acc_adr_s] <= acc_dat_s;
        end
    end
endmodule
